// File: rtl/q115_pkg.sv
// Shared Q1.15 constants, core EXECUTE code and the mac_accum state enum;
// the activation unit imports the same package.
package q115_pkg;

  localparam logic [15:0] Q115_MAX  = 16'h7FFF;
  localparam logic [15:0] Q115_MIN  = 16'h8000;
  localparam logic [15:0] Q115_ZERO = 16'h0000;

  localparam logic [2:0] CORE_EXECUTE = 3'b101;

  typedef enum logic [1:0] {
    MAC_IDLE,
    MAC_ACCUM,
    MAC_DRAIN,
    MAC_DONE
  } mac_state_t;

endpackage

// File: rtl/q115_mul.sv
// Registered Q1.15 multiplier: full signed product scaled back by 2^15.
// Build option MAC_ROUND_EN: round half up before scaling instead of truncating.
module q115_mul #(
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fire,
  input  logic [DATA_BITS-1:0] a_data,
  input  logic [DATA_BITS-1:0] b_data,
  output logic [DATA_BITS:0]   product,
  output logic                 product_valid
);

  localparam int FULL_BITS = 2 * DATA_BITS;

  logic signed [FULL_BITS-1:0] a_ext;
  logic signed [FULL_BITS-1:0] b_ext;
  logic signed [FULL_BITS-1:0] full_product;
  logic                        unused_low_bits;

`ifdef MAC_ROUND_EN
  localparam logic signed [FULL_BITS-1:0] ROUND_BIAS = FULL_BITS'(1) << (DATA_BITS - 2);
`endif

  // The scaled product needs one bit more than an operand: -1.0 * -1.0 = +1.0.
  always_comb begin
    a_ext = FULL_BITS'($signed(a_data));
    b_ext = FULL_BITS'($signed(b_data));
`ifdef MAC_ROUND_EN
    full_product = (a_ext * b_ext) + ROUND_BIAS;
`else
    full_product = a_ext * b_ext;
`endif
  end

  assign unused_low_bits = ^full_product[DATA_BITS-2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      product       <= '0;
      product_valid <= 1'b0;
    end else if (enable) begin
      product_valid <= fire;
      if (fire)
        product <= full_product[FULL_BITS-1:DATA_BITS-1];
    end
  end

endmodule

// File: rtl/mac_accum.sv
// Q1.15 dot-product engine: multiply stage, saturating accumulator and output clamp.
// MAC_ROUND_EN (see q115_mul) selects rounded rather than truncated products.
module mac_accum
  import q115_pkg::*;
#(
  parameter int DATA_BITS = 16,
  parameter int ACC_BITS  = 24,
  parameter int LEN_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 start,
  input  logic [LEN_BITS-1:0]  length,
  input  logic [DATA_BITS-1:0] a_data,
  input  logic [DATA_BITS-1:0] b_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATA_BITS-1:0] unbiased_activation,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam logic signed [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};
  localparam logic signed [ACC_BITS-1:0] RES_MAX = ACC_BITS'({1'b0, {(DATA_BITS-1){1'b1}}});
  localparam logic signed [ACC_BITS-1:0] RES_MIN = ~RES_MAX;

  mac_state_t                 state;
  mac_state_t                 state_next;
  logic [LEN_BITS-1:0]        remaining;
  logic signed [ACC_BITS-1:0] acc;
  logic signed [ACC_BITS-1:0] acc_sum_sat;
  logic signed [ACC_BITS-1:0] product_ext;
  logic signed [ACC_BITS:0]   acc_sum;
  logic [DATA_BITS:0]         product;
  logic                       product_valid;
  logic                       fire;
  logic                       start_ok;
  logic                       last_pair;
  logic [DATA_BITS-1:0]       clamped;

  assign in_ready  = enable && (state == MAC_ACCUM) && (remaining != '0);
  assign fire      = in_valid && in_ready;
  assign start_ok  = start && (core_state == CORE_EXECUTE) && (state == MAC_IDLE);
  assign last_pair = (remaining == LEN_BITS'(1));
  assign out_valid = (state == MAC_DONE);
  assign busy      = (state != MAC_IDLE);

  q115_mul #(.DATA_BITS(DATA_BITS)) u_mul (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fire         (fire),
    .a_data       (a_data),
    .b_data       (b_data),
    .product      (product),
    .product_valid(product_valid)
  );

  // One extra bit on the sum exposes signed overflow of the accumulator.
  always_comb begin
    product_ext = ACC_BITS'($signed(product));
    acc_sum     = (ACC_BITS+1)'(acc) + (ACC_BITS+1)'(product_ext);
    acc_sum_sat = acc_sum[ACC_BITS-1:0];
    if (acc_sum[ACC_BITS] != acc_sum[ACC_BITS-1])
      acc_sum_sat = acc_sum[ACC_BITS] ? ACC_MIN : ACC_MAX;

    clamped = acc[DATA_BITS-1:0];
    if (acc > RES_MAX)
      clamped = {1'b0, {(DATA_BITS-1){1'b1}}};
    else if (acc < RES_MIN)
      clamped = {1'b1, {(DATA_BITS-1){1'b0}}};
  end

  always_comb begin
    state_next = state;
    case (state)
      MAC_IDLE:  if (start_ok) state_next = (length == '0) ? MAC_DONE : MAC_ACCUM;
      MAC_ACCUM: if (fire && last_pair) state_next = MAC_DRAIN;
      MAC_DRAIN: if (!product_valid) state_next = MAC_DONE;
      MAC_DONE:  if (out_ready) state_next = MAC_IDLE;
      default:   state_next = MAC_IDLE;
    endcase
  end

  // Result is captured once on entry to DONE so it stays stable while waiting for out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= MAC_IDLE;
      remaining           <= '0;
      acc                 <= '0;
      unbiased_activation <= '0;
    end else if (enable) begin
      state <= state_next;
      if (start_ok) begin
        remaining <= length;
        acc       <= '0;
      end else begin
        if (fire)
          remaining <= remaining - LEN_BITS'(1);
        if (product_valid)
          acc <= acc_sum_sat;
      end
      if ((state_next == MAC_DONE) && (state != MAC_DONE))
        unbiased_activation <= (state == MAC_IDLE) ? '0 : clamped;
    end
  end

endmodule

// File: tb/tb_mac_accum.sv
// Self-checking bench for mac_accum: directed vector table, corner sequences and
// randomized dot products checked against an arithmetic reference model.
module tb_mac_accum;
  import q115_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  core_state;
  logic        start;
  logic [7:0]  length;
  logic [15:0] a_data;
  logic [15:0] b_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] unbiased_activation;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  typedef struct {
    string       name;
    int          len;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] expected;
  } vec_t;

  vec_t vecs[9];

  mac_accum #(.DATA_BITS(16), .ACC_BITS(24), .LEN_BITS(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .core_state         (core_state),
    .start              (start),
    .length             (length),
    .a_data             (a_data),
    .b_data             (b_data),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .unbiased_activation(unbiased_activation),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  // Reference: exact products, scale by 2^15 with floor, saturate the 24-bit sum, clamp to Q1.15.
  function automatic logic [15:0] ref_dot(input int n);
    longint acc;
    longint p;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      p = longint'($signed(qa[i])) * longint'($signed(qb[i]));
`ifdef MAC_ROUND_EN
      p = p + 16384;
`endif
      p = p >>> 15;
      acc = acc + p;
      if (acc > 64'sd8388607) acc = 64'sd8388607;
      if (acc < -64'sd8388608) acc = -64'sd8388608;
    end
    if (acc > 32767) return Q115_MAX;
    if (acc < -32768) return Q115_MIN;
    return 16'(acc);
  endfunction

  function automatic logic [15:0] pick_operand();
    logic [15:0] corner[4];
    corner[0] = 16'h7FFF;
    corner[1] = 16'h8000;
    corner[2] = 16'h0000;
    corner[3] = 16'hFFFF;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one dot product over qa/qb, checks latency and result, holds the output, then releases it.
  task automatic applyStimulus(input string name, input int len, input logic [15:0] expected,
                               input bit gaps, input int hold, input bit poke_start);
    int idx;
    int guard;
    int cnt;
    bit took;
    start      = 1'b1;
    length     = 8'(len);
    core_state = CORE_EXECUTE;
    step();
    start = 1'b0;
    if (len == 0) begin
      checkOutput({name, "_in_ready"}, 32'(in_ready), 32'd0);
      checkOutput({name, "_valid_next"}, 32'(out_valid), 32'd1);
    end else begin
      idx   = 0;
      guard = 0;
      while (idx < len && guard < 200) begin
        in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        a_data   = qa[idx];
        b_data   = qb[idx];
        took     = in_valid && in_ready;
        step();
        if (took) idx++;
        guard++;
      end
      in_valid = 1'b0;
      checkOutput({name, "_transfers"}, 32'(idx), 32'(len));
      cnt = 1;
      while (!out_valid && cnt < 20) begin
        step();
        cnt++;
      end
      checkOutput({name, "_latency"}, 32'(cnt), 32'd3);
    end
    checkOutput({name, "_result"}, 32'(unbiased_activation), 32'(expected));
    for (int i = 0; i < hold; i++) begin
      if (poke_start) begin
        start  = (i % 2 == 0);
        length = 8'd2;
      end
      step();
    end
    start = 1'b0;
    if (hold > 0)
      checkOutput({name, "_held"}, 32'({out_valid, unbiased_activation}), 32'({1'b1, expected}));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({name, "_released"}, 32'({out_valid, busy}), 32'd0);
  endtask

  task automatic load_pairs(input int len, input logic [15:0] a, input logic [15:0] b);
    qa.delete();
    qb.delete();
    for (int i = 0; i < len; i++) begin
      qa.push_back(a);
      qb.push_back(b);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len;
    int cnt;
    logic [15:0] expected;

    vecs[0] = '{"half_sq",    1, 16'h4000, 16'h4000, 16'h2000};
    vecs[1] = '{"pos_sat",    4, 16'h7FFF, 16'h7FFF, Q115_MAX};
    vecs[2] = '{"neg_sat",    4, 16'h8000, 16'h7FFF, Q115_MIN};
    vecs[3] = '{"plus_one",   1, 16'h8000, 16'h8000, Q115_MAX};
`ifdef MAC_ROUND_EN
    vecs[4] = '{"round_lsb",  1, 16'h0001, 16'h4000, 16'h0001};
    vecs[5] = '{"neg_lsb",    1, 16'hFFFF, 16'h0001, 16'h0000};
`else
    vecs[4] = '{"round_lsb",  1, 16'h0001, 16'h4000, 16'h0000};
    vecs[5] = '{"neg_lsb",    1, 16'hFFFF, 16'h0001, 16'hFFFF};
`endif
    vecs[6] = '{"len_zero",   0, 16'h1234, 16'h5678, Q115_ZERO};
    vecs[7] = '{"three_acc",  3, 16'h2000, 16'h2000, 16'h1800};
    vecs[8] = '{"neg_sum",    2, 16'hC000, 16'h4000, 16'hC000};

    reset      = 1'b1;
    enable     = 1'b1;
    core_state = CORE_EXECUTE;
    start      = 1'b0;
    length     = '0;
    a_data     = '0;
    b_data     = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    step();
    step();
    reset = 1'b0;
    checkOutput("reset_outputs", 32'({out_valid, busy, in_ready}), 32'd0);
    checkOutput("reset_result", 32'(unbiased_activation), 32'(Q115_ZERO));

    foreach (vecs[i]) begin
      load_pairs(vecs[i].len, vecs[i].a, vecs[i].b);
      applyStimulus(vecs[i].name, vecs[i].len, vecs[i].expected, 1'b0, 1, 1'b0);
    end

    // Output held five cycles while start pulses arrive; none may be taken.
    load_pairs(1, 16'h4000, 16'h4000);
    applyStimulus("hold_starts", 1, 16'h2000, 1'b0, 5, 1'b1);
    step();
    checkOutput("hold_starts_idle", 32'({busy, in_ready}), 32'd0);

    // start while the core is not in EXECUTE is ignored.
    start      = 1'b1;
    length     = 8'd3;
    core_state = 3'b100;
    step();
    start      = 1'b0;
    core_state = CORE_EXECUTE;
    checkOutput("non_exec_start", 32'({busy, in_ready}), 32'd0);

    // Stalls: enable low in ACCUM, DRAIN and DONE freezes everything.
    load_pairs(2, 16'h4000, 16'h4000);
    start  = 1'b1;
    length = 8'd2;
    step();
    start  = 1'b0;
    enable = 1'b0;
    #1;
    checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    enable   = 1'b1;
    in_valid = 1'b1;
    a_data   = qa[0];
    b_data   = qb[0];
    step();
    step();
    in_valid = 1'b0;
    enable   = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checkOutput("stall_drain", 32'({out_valid, busy}), 32'b01);
    enable = 1'b1;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      step();
      cnt++;
    end
    checkOutput("stall_resume_latency", 32'(cnt), 32'd2);
    checkOutput("stall_result", 32'(unbiased_activation), 32'h4000);
    enable    = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    checkOutput("stall_done_hold", 32'({out_valid, unbiased_activation}), 32'h14000);
    enable = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("stall_released", 32'({out_valid, busy}), 32'd0);

    // Reset mid-ACCUM, asserted with enable low to show reset wins.
    load_pairs(4, 16'h7FFF, 16'h7FFF);
    start  = 1'b1;
    length = 8'd4;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    a_data   = qa[0];
    b_data   = qb[0];
    step();
    step();
    in_valid = 1'b0;
    reset    = 1'b1;
    enable   = 1'b0;
    step();
    reset  = 1'b0;
    enable = 1'b1;
    #1;
    checkOutput("mid_reset_outputs", 32'({out_valid, busy, in_ready}), 32'd0);
    checkOutput("mid_reset_result", 32'(unbiased_activation), 32'd0);
    load_pairs(1, 16'h4000, 16'h4000);
    applyStimulus("after_reset", 1, 16'h2000, 1'b0, 0, 1'b0);

    // Randomized dot products against the reference model.
    for (int r = 0; r < 25; r++) begin
      len = $urandom_range(0, 6);
      qa.delete();
      qb.delete();
      for (int i = 0; i < len; i++) begin
        qa.push_back(pick_operand());
        qb.push_back(pick_operand());
      end
      expected = ref_dot(len);
      applyStimulus($sformatf("rand%0d", r), len, expected, 1'b1, $urandom_range(0, 2), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mac_accum.md
MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 SHALL have parameter DATA_BITS, default 16, Q1.15 operand/result width.
REQ-002 SHALL have parameter ACC_BITS, default 24, signed internal accumulator width (≥ DATA_BITS+2).
REQ-003 SHALL have parameter LEN_BITS, default 8, dot-product length width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  global stall; when low, all state and outputs hold.
REQ-007 core_state  input  3  core FSM state; 3'b101 = EXECUTE.
REQ-008 start  input  1  one-cycle request to begin a dot product.
REQ-009 length  input  LEN_BITS  number of operand pairs, sampled with start.
REQ-010 a_data, b_data  input  DATA_BITS each  Q1.15 operand pair.
REQ-011 in_valid / in_ready  input / output  1 each  operand handshake; pair transfers when both high.
REQ-012 unbiased_activation  output  DATA_BITS  saturated Q1.15 sum, feeds bias/activation unit.
REQ-013 out_valid / out_ready  output / input  1 each  result handshake.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, ACCUM, DRAIN, DONE.
REQ-016 IDLE->ACCUM when enable & start & core_state==3'b101 & length!=0; clears accumulator, loads remaining=length.
REQ-017 IDLE->DONE when same condition with length==0; result 0x0000, out_valid high the next cycle.
REQ-018 start outside IDLE, or with core_state≠EXECUTE, SHALL be ignored.
REQ-019 in_ready = enable & (state==ACCUM) & (remaining!=0), combinational; each transfer decrements remaining.
REQ-020 Product stage: signed DATA_BITS×DATA_BITS -> 2·DATA_BITS product, scaled >>>15 (see REQ-029), registered with a valid bit (1 cycle).
REQ-021 Accumulate stage: sign-extended product added to accumulator at ACC_BITS, saturating at ACC_BITS signed limits (1 cycle).
REQ-022 ACCUM->DRAIN on the cycle the last pair transfers; DRAIN->DONE once the last product has been accumulated.
REQ-023 Latency: last pair accepted in cycle t -> out_valid high in cycle t+3, unbiased_activation valid in the same cycle.
REQ-024 Output clamp: accumulator > 0x7FFF -> 0x7FFF; < -0x8000 -> 0x8000; else low DATA_BITS bits.
REQ-025 DONE holds out_valid and unbiased_activation stable until out_ready; on handshake -> IDLE, out_valid low next cycle.
REQ-026 out_ready high while out_valid low SHALL have no effect.
REQ-027 enable low in any state freezes the pipeline, counters and outputs; in_ready is low.

Reset
REQ-028 reset SHALL force IDLE, accumulator 0, remaining 0, product-valid 0, unbiased_activation 0x0000, out_valid 0, in_ready 0, busy 0; mid-operation reset discards partial sums; reset has priority over enable.

Configuration
REQ-029 Macro MAC_ROUND_EN: defined -> add 0x4000 to the product before >>>15 (round half up); undefined -> plain truncating >>>15.

Structure
REQ-030 Package q115_pkg SHALL hold Q115_MAX, Q115_MIN, Q115_ZERO, the EXECUTE state code 3'b101 and the mac_accum state enum; these are shared with the activation unit.
REQ-031 Product stage SHALL be sub-module q115_mul (multiply, optional round, scale, output register).

Verification
REQ-032 length=1, a=b=0x4000 -> unbiased_activation 0x2000, out_valid 3 cycles after transfer.
REQ-033 length=4, all pairs 0x7FFF×0x7FFF -> 0x7FFF (positive saturation); 4× 0x8000×0x7FFF -> 0x8000.
REQ-034 length=1, a=b=0x8000 (+1.0 product) -> 0x7FFF.
REQ-035 length=0 -> 0x0000 with out_valid the cycle after start; no in_ready pulse.
REQ-036 a=0x0001, b=0x4000 -> 0x0001 with MAC_ROUND_EN, 0x0000 without.
REQ-037 out_ready held low 5 cycles with start pulses -> output stable, starts ignored; reset mid-ACCUM -> IDLE, all outputs 0 next cycle.
